// File: rtl/if_fetch.sv
// Instruction fetch: PC register, icache lookup and a byte-serial miss fill through
// the memory controller. One instruction per cycle on hits; honours stall and redirect.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        icache_read_o,
  output logic [31:0] icache_read_addr_o,
  input  logic        icache_hit_i,
  input  logic [31:0] icache_inst_i,
  output logic        icache_write_o,
  output logic [31:0] icache_write_addr_o,
  output logic [31:0] icache_write_inst_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  typedef enum logic [1:0] {LOOKUP, FETCH, DONE} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [2:0]      issue_q, issue_d;
  logic [2:0]      recv_q, recv_d;
  logic            gnt_dly_q, gnt_dly_d;
  logic [3:0][7:0] asm_q, asm_d;
  logic [31:0]     if_pc_q, if_pc_d;
  logic [31:0]     if_inst_q, if_inst_d;
  logic            if_valid_q, if_valid_d;
  logic            deliver;
  logic [31:0]     deliver_inst;

  always_comb begin
    state_d             = state_q;
    pc_d                = pc_q;
    issue_d             = issue_q;
    recv_d              = recv_q;
    gnt_dly_d           = 1'b0;
    asm_d               = asm_q;
    if_pc_d             = if_pc_q;
    if_inst_d           = if_inst_q;
    if_valid_d          = if_valid_q;
    deliver             = 1'b0;
    deliver_inst        = '0;
    icache_read_o       = 1'b0;
    icache_read_addr_o  = '0;
    icache_write_o      = 1'b0;
    icache_write_addr_o = '0;
    icache_write_inst_o = '0;
    mem_req_o           = 1'b0;
    mem_addr_o          = '0;

    unique case (state_q)
      LOOKUP: begin
        icache_read_o      = 1'b1;
        icache_read_addr_o = pc_q;
        if (icache_hit_i) begin
          if (!stall_i) begin
            deliver      = 1'b1;
            deliver_inst = icache_inst_i;
          end
        end else begin
          state_d = FETCH;
          issue_d = '0;
          recv_d  = '0;
        end
      end
      FETCH: begin
        mem_req_o  = (issue_q < 3'd4);
        mem_addr_o = pc_q + {29'b0, issue_q};
        if (mem_req_o && mem_gnt_i) issue_d = issue_q + 3'd1;
        // Flag marks that the byte on mem_data_i next cycle belongs to this fill.
        gnt_dly_d = mem_req_o && mem_gnt_i;
        if (gnt_dly_q) begin
          asm_d[recv_q[1:0]] = mem_data_i;
          recv_d             = recv_q + 3'd1;
          if (recv_q == 3'd3) state_d = DONE;
        end
      end
      DONE: begin
        icache_write_o      = 1'b1;
        icache_write_addr_o = pc_q;
        icache_write_inst_o = asm_q;
        if (!stall_i) begin
          deliver      = 1'b1;
          deliver_inst = asm_q;
          state_d      = LOOKUP;
        end
      end
      default: state_d = LOOKUP;
    endcase

    if (deliver) begin
      if_pc_d    = pc_q;
      if_inst_d  = deliver_inst;
      if_valid_d = 1'b1;
      pc_d       = pc_q + 32'd4;
    end else if (!stall_i) begin
      if_valid_d = 1'b0;
    end

    // Redirect overrides stall and any fill in progress; pending byte is dropped.
    if (branch_i) begin
      pc_d       = branch_addr_i & ~32'h3;
      if_valid_d = 1'b0;
      state_d    = LOOKUP;
      issue_d    = '0;
      recv_d     = '0;
      gnt_dly_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= LOOKUP;
      pc_q       <= RESET_PC;
      issue_q    <= '0;
      recv_q     <= '0;
      gnt_dly_q  <= 1'b0;
      asm_q      <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issue_q    <= issue_d;
      recv_q     <= recv_d;
      gnt_dly_q  <= gnt_dly_d;
      asm_q      <= asm_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign if_pc_o    = if_pc_q;
  assign if_inst_o  = if_inst_q;
  assign if_valid_o = if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: behavioural icache and byte-wide memory models, with a scoreboard
// of expected {pc, inst} deliveries consumed whenever if_valid_o is taken (not stalled).
`timescale 1ns/100ps
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, branch_i;
  logic [31:0] branch_addr_i;
  logic        icache_read_o, icache_hit_i, icache_write_o;
  logic [31:0] icache_read_addr_o, icache_inst_i, icache_write_addr_o, icache_write_inst_o;
  logic        mem_req_o, mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_i;
  logic [31:0] if_pc_o, if_inst_o;
  logic        if_valid_o;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .icache_read_o(icache_read_o), .icache_read_addr_o(icache_read_addr_o),
    .icache_hit_i(icache_hit_i), .icache_inst_i(icache_inst_i),
    .icache_write_o(icache_write_o), .icache_write_addr_o(icache_write_addr_o),
    .icache_write_inst_o(icache_write_inst_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i), .mem_data_i(mem_data_i),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_valid_o(if_valid_o)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } exp_t;

  logic [7:0]  mem [0:1023];
  logic [31:0] cache [logic [31:0]];
  exp_t        sbq [$];
  int          checks = 0, errors = 0, cyc = 0;
  bit          gnt_mode = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] paddr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [9:0] i;
    i = a[9:0];
    return {mem[i + 10'd3], mem[i + 10'd2], mem[i + 10'd1], mem[i]};
  endfunction

  // Drive grant and the combinational icache response for the current lookup address.
  task automatic settle();
    mem_gnt_i = gnt_mode ? (cyc % 2 == 1) : 1'b1;
    #1;
    icache_hit_i  = icache_read_o && cache.exists(icache_read_addr_o);
    icache_inst_i = icache_hit_i ? cache[icache_read_addr_o] : 32'hDEAD_BEEF;
    #1;
  endtask

  // Consume deliveries / fills, clock one edge, then return the granted byte.
  task automatic advance();
    exp_t e;
    if (rst && if_valid_o && !stall_i) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected cyc=%0d got pc=%h inst=%h, expected no delivery", cyc, if_pc_o, if_inst_o);
      end else begin
        e = sbq.pop_front();
        if (if_pc_o !== e.pc || if_inst_o !== e.inst) begin
          errors++;
          $display("FAIL sb_deliver cyc=%0d got pc=%h inst=%h, expected pc=%h inst=%h",
                   cyc, if_pc_o, if_inst_o, e.pc, e.inst);
        end
      end
    end
    if (rst && icache_write_o) begin
      checks++;
      if (icache_write_inst_o !== mem_word(icache_write_addr_o)) begin
        errors++;
        $display("FAIL fill_data cyc=%0d addr=%h got %h, expected %h",
                 cyc, icache_write_addr_o, icache_write_inst_o, mem_word(icache_write_addr_o));
      end
      cache[icache_write_addr_o] = mem_word(icache_write_addr_o);
    end
    pend  = mem_req_o && mem_gnt_i;
    paddr = mem_addr_o;
    @(posedge clk);
    @(negedge clk);
    mem_data_i = pend ? mem[paddr[9:0]] : 8'hEE;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    stall_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin settle(); advance(); end
    rst = 1'b1;
    sbq.delete();
    cyc = 0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sbq.size() > 0; i++) begin settle(); advance(); end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending deliveries, expected 0", name, sbq.size());
    end
  endtask

  task automatic test_reset();
    cache.delete();
    stall_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    rst = 1'b0;
    settle(); advance();
    settle();
    checks++;
    if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_out got v=%b pc=%h inst=%h, expected 0/0/0", if_valid_o, if_pc_o, if_inst_o);
    end
    advance();
    rst = 1'b1; cyc = 0;
    settle();
    checks++;
    if (icache_read_addr_o !== 32'h0 || icache_read_o !== 1'b1 || mem_req_o !== 1'b0 ||
        icache_write_o !== 1'b0 || if_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got raddr=%h rd=%b req=%b wr=%b v=%b, expected 0/1/0/0/0",
               icache_read_addr_o, icache_read_o, mem_req_o, icache_write_o, if_valid_o);
    end
    advance();
  endtask

  task automatic test_cold_miss();
    cache.delete();
    do_reset(2);
    sbq.push_back('{pc: 32'h0, inst: 32'h0010_0513});
    for (int c = 0; c <= 7; c++) begin
      settle();
      if (c >= 1 && c <= 4) begin
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'(c - 1)) begin
          errors++;
          $display("FAIL cold_req cyc=%0d got req=%b addr=%h, expected 1/%h", c, mem_req_o, mem_addr_o, c - 1);
        end
      end
      if (c == 6) begin
        checks++;
        if (icache_write_o !== 1'b1 || icache_write_addr_o !== 32'h0 || icache_write_inst_o !== 32'h0010_0513) begin
          errors++;
          $display("FAIL cold_fill got wr=%b addr=%h data=%h, expected 1/0/00100513",
                   icache_write_o, icache_write_addr_o, icache_write_inst_o);
        end
      end
      if (c == 6 || c == 7) begin
        checks++;
        if (if_valid_o !== (c == 7)) begin
          errors++;
          $display("FAIL cold_valid cyc=%0d got %b, expected %b", c, if_valid_o, c == 7);
        end
      end
      advance();
    end
    drain("cold");
  endtask

  task automatic test_warm_loop();
    cache.delete();
    for (int i = 0; i < 4; i++) cache[32'h100 + 32'(4 * i)] = 32'hC0DE_0000 + 32'(i * 17 + 1);
    do_reset(2);
    branch_i = 1'b1; branch_addr_i = 32'h100;
    settle(); advance();
    branch_i = 1'b0;
    for (int i = 0; i < 4; i++) sbq.push_back('{pc: 32'h100 + 32'(4 * i), inst: 32'hC0DE_0000 + 32'(i * 17 + 1)});
    for (int c = 1; c <= 5; c++) begin
      settle();
      if (c >= 2) begin
        checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100 + 32'(4 * (c - 2))) begin
          errors++;
          $display("FAIL warm_seq cyc=%0d got v=%b pc=%h, expected 1/%h", c, if_valid_o, if_pc_o, 32'h100 + 32'(4 * (c - 2)));
        end
      end
      advance();
    end
    drain("warm");
  endtask

  task automatic test_gnt_gap();
    cache.delete();
    gnt_mode = 1'b1;
    do_reset(2);
    sbq.push_back('{pc: 32'h0, inst: 32'h0010_0513});
    for (int c = 0; c <= 10; c++) begin
      settle();
      if (c == 9) begin
        checks++;
        if (icache_write_o !== 1'b1) begin
          errors++;
          $display("FAIL gap_fill_cycle got wr=%b at cyc 9, expected 1", icache_write_o);
        end
      end
      if (c == 7 || c == 10) begin
        checks++;
        if (if_valid_o !== (c == 10)) begin
          errors++;
          $display("FAIL gap_valid cyc=%0d got %b, expected %b", c, if_valid_o, c == 10);
        end
      end
      advance();
    end
    gnt_mode = 1'b0;
    drain("gap");
  endtask

  task automatic test_branch();
    cache.delete();
    do_reset(2);
    for (int c = 0; c <= 3; c++) begin settle(); advance(); end
    branch_i = 1'b1; branch_addr_i = 32'h203;
    settle(); advance();
    branch_i = 1'b0;
    sbq.push_back('{pc: 32'h200, inst: mem_word(32'h200)});
    settle();
    checks++;
    if (if_valid_o !== 1'b0 || icache_read_o !== 1'b1 || icache_read_addr_o !== 32'h200 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL branch_redirect got v=%b rd=%b raddr=%h req=%b, expected 0/1/00000200/0",
               if_valid_o, icache_read_o, icache_read_addr_o, mem_req_o);
    end
    advance();
    settle();
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin
      errors++;
      $display("FAIL branch_refetch got req=%b addr=%h, expected 1/00000200", mem_req_o, mem_addr_o);
    end
    advance();
    drain("branch");
  endtask

  task automatic test_stall();
    cache.delete();
    for (int i = 0; i < 3; i++) cache[32'h100 + 32'(4 * i)] = 32'h5EED_0000 + 32'(i * 3 + 7);
    do_reset(2);
    branch_i = 1'b1; branch_addr_i = 32'h100;
    settle(); advance();
    branch_i = 1'b0;
    for (int i = 0; i < 3; i++) sbq.push_back('{pc: 32'h100 + 32'(4 * i), inst: 32'h5EED_0000 + 32'(i * 3 + 7)});
    sbq.push_back('{pc: 32'h10C, inst: mem_word(32'h10C)});
    for (int c = 1; c <= 17; c++) begin
      stall_i = (c >= 2 && c <= 4) || (c >= 13 && c <= 15);
      settle();
      if (c >= 2 && c <= 4) begin
        checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100 || icache_read_addr_o !== 32'h104) begin
          errors++;
          $display("FAIL stall_hit cyc=%0d got v=%b pc=%h raddr=%h, expected 1/00000100/00000104",
                   c, if_valid_o, if_pc_o, icache_read_addr_o);
        end
      end
      if (c >= 13 && c <= 15) begin
        checks++;
        if (icache_write_o !== 1'b1 || icache_write_addr_o !== 32'h10C || if_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL stall_done cyc=%0d got wr=%b waddr=%h v=%b, expected 1/0000010c/0",
                   c, icache_write_o, icache_write_addr_o, if_valid_o);
        end
      end
      if (c == 17) begin
        checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h10C || icache_read_addr_o !== 32'h110) begin
          errors++;
          $display("FAIL stall_resume got v=%b pc=%h raddr=%h, expected 1/0000010c/00000110",
                   if_valid_o, if_pc_o, icache_read_addr_o);
        end
      end
      advance();
    end
    stall_i = 1'b0;
    drain("stall");
  endtask

  task automatic test_reset_midfill();
    cache.delete();
    do_reset(2);
    for (int c = 0; c <= 2; c++) begin settle(); advance(); end
    do_reset(1);
    sbq.push_back('{pc: 32'h0, inst: 32'h0010_0513});
    for (int c = 0; c <= 7; c++) begin
      settle();
      if (c == 0) begin
        checks++;
        if (if_valid_o !== 1'b0 || icache_read_addr_o !== 32'h0 || mem_req_o !== 1'b0 || icache_write_o !== 1'b0) begin
          errors++;
          $display("FAIL midfill_clear got v=%b raddr=%h req=%b wr=%b, expected 0/0/0/0",
                   if_valid_o, icache_read_addr_o, mem_req_o, icache_write_o);
        end
      end
      if (c == 7) begin
        checks++;
        if (if_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL midfill_valid got %b at cyc 7, expected 1", if_valid_o);
        end
      end
      advance();
    end
    drain("midfill");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    mem_data_i = 8'hEE; mem_gnt_i = 1'b1; icache_hit_i = 1'b0; icache_inst_i = '0;
    @(negedge clk);
    test_reset();
    test_cold_miss();
    test_warm_loop();
    test_gnt_gap();
    test_branch();
    test_stall();
    test_reset_midfill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
